// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised operand stack.
// Contents:
//   op_e   - operation select encodings driven by the instruction decoder
//   CNT_W  - width of the occupancy count for a given depth (0..DEPTH)
package stack_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  // Count must represent every value from 0 up to and including depth.
  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Decoder/ALU-facing bundle of the operand stack.
//   i, s, err_clr            - data, operation select, error-flag clear (decoder -> stack)
//   T, N                     - top and next-of-stack entries (stack -> ALU)
//   count, empty, full       - occupancy status
//   ovf, unf                 - sticky overflow / underflow flags
// master: the decoder side; slave: the stack itself.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import stack_pkg::*;

  localparam int CW = CNT_W(DEPTH);

  logic [WIDTH-1:0] i;
  logic [1:0]       s;
  logic             err_clr;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] N;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output i, s, err_clr,
    input  T, N, count, empty, full, ovf, unf
  );

  modport slave (
    input  i, s, err_clr,
    output T, N, count, empty, full, ovf, unf
  );

endinterface

// File: rtl/stack_occ.sv
// Occupancy tracker for the operand stack: saturating entry count plus
// registered empty/full status and sticky overflow/underflow flags.
//   ck, rst_n - clock, asynchronous active-low reset
//   s         - operation select (op_e encoding)
//   err_clr   - synchronous clear of ovf/unf; a same-cycle error event wins
//   count     - valid entries, 0..DEPTH
//   empty     - count == 0
//   full      - count == DEPTH
//   ovf, unf  - sticky push-while-full / pop-while-empty
module stack_occ
  import stack_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = CNT_W(DEPTH)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [1:0]    s,
  input  logic          err_clr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  logic [CW-1:0] count_r;
  logic          empty_r;
  logic          full_r;
  logic          ovf_r;
  logic          unf_r;
  logic [CW-1:0] count_nxt_s;
  logic          ovf_evt_s;
  logic          unf_evt_s;

  // Next count and error events; the count never wraps past 0 or DEPTH.
  always_comb begin
    count_nxt_s = count_r;
    ovf_evt_s   = 1'b0;
    unf_evt_s   = 1'b0;
    case (op_e'(s))
      OP_PUSH: begin
        if (full_r) begin
          ovf_evt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_r) begin
          unf_evt_s = 1'b1;
        end else begin
          count_nxt_s = count_r - CW'(1);
        end
      end
      OP_REPL: begin
        // Replacing on an empty stack creates the first entry.
        if (empty_r) begin
          count_nxt_s = CW'(1);
        end else begin
          count_nxt_s = count_r;
        end
      end
      OP_HOLD: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy and flag registers; status flags are pre-decoded from the next count.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CW'(0);
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CW'(0));
      full_r  <= (count_nxt_s == CW'(DEPTH));
      ovf_r   <= ovf_evt_s | (ovf_r & ~err_clr);
      unf_r   <= unf_evt_s | (unf_r & ~err_clr);
    end
  end

  assign count = count_r;
  assign empty = empty_r;
  assign full  = full_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack between the instruction decoder and the ALU.
// Entries form a pure shift structure (entry 0 is the top); invalid entries
// always hold zero so T/N read as zero when the stack is shallow.
//   ck, rst_n - clock, asynchronous active-low reset
//   bus       - param_stack_if slave: i/s/err_clr in; T/N/count/flags out
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  param_stack_if.slave bus
);

  logic [WIDTH-1:0] e_r   [DEPTH];
  logic [WIDTH-1:0] e_nxt_s [DEPTH];

  // Shift muxing per operation.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      e_nxt_s[k] = e_r[k];
    end
    case (op_e'(bus.s))
      OP_PUSH: begin
        // Bottom entry falls off when full.
        e_nxt_s[0] = bus.i;
        for (int k = 1; k < DEPTH; k++) begin
          e_nxt_s[k] = e_r[k-1];
        end
      end
      OP_POP: begin
        // On an empty stack this shifts zeros into zeros, so nothing changes.
        for (int k = 0; k < DEPTH - 1; k++) begin
          e_nxt_s[k] = e_r[k+1];
        end
        e_nxt_s[DEPTH-1] = {WIDTH{1'b0}};
      end
      OP_REPL: e_nxt_s[0] = bus.i;
      OP_HOLD: e_nxt_s[0] = e_r[0];
      default: e_nxt_s[0] = e_r[0];
    endcase
  end

  // Entry storage.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        e_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        e_r[k] <= e_nxt_s[k];
      end
    end
  end

  assign bus.T = e_r[0];
  assign bus.N = e_r[1];

  stack_occ #(
    .DEPTH (DEPTH)
  ) u_occ (
    .ck      (ck),
    .rst_n   (rst_n),
    .s       (bus.s),
    .err_clr (bus.err_clr),
    .count   (bus.count),
    .empty   (bus.empty),
    .full    (bus.full),
    .ovf     (bus.ovf),
    .unf     (bus.unf)
  );

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: directed scenarios on an 8-bit x 4 stack, then a
// random stream on a 16-bit x 2 stack compared against a queue reference.
module tb_param_stack;
  import stack_pkg::*;

  logic ck = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 ck = ~ck;

  param_stack_if #(.WIDTH(8),  .DEPTH(4)) bus  ();
  param_stack_if #(.WIDTH(16), .DEPTH(2)) bus2 ();

  param_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  param_stack #(.WIDTH(16), .DEPTH(2)) dut2 (
    .ck    (ck),
    .rst_n (rst2_n),
    .bus   (bus2.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full output check of the 8x4 stack.
  task automatic chk(input string tag, input logic [7:0] t, input logic [7:0] n,
                     input logic [2:0] cnt, input logic emp, input logic ful,
                     input logic o, input logic u);
    check({tag, ".T"},     32'(bus.T),     32'(t));
    check({tag, ".N"},     32'(bus.N),     32'(n));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".empty"}, 32'(bus.empty), 32'(emp));
    check({tag, ".full"},  32'(bus.full),  32'(ful));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(o));
    check({tag, ".unf"},   32'(bus.unf),   32'(u));
  endtask

  // Apply one operation and sample 1 time unit after the capturing edge.
  task automatic step(input op_e op, input logic [7:0] d, input logic clr);
    bus.s       = op;
    bus.i       = d;
    bus.err_clr = clr;
    @(posedge ck);
    #1;
  endtask

  logic [15:0] q[$];
  logic        ovf_m;
  logic        unf_m;
  logic [1:0]  sv;
  logic [15:0] iv;
  logic        cv;

  initial begin
    rst_n        = 1'b0;
    rst2_n       = 1'b0;
    bus.s        = OP_HOLD;
    bus.i        = 8'h00;
    bus.err_clr  = 1'b0;
    bus2.s       = OP_HOLD;
    bus2.i       = 16'h0000;
    bus2.err_clr = 1'b0;
    #12;
    chk("reset", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset2.count", 32'(bus2.count), 32'd0);
    rst_n = 1'b1;

    // Three pushes.
    step(OP_PUSH, 8'h11, 1'b0);
    step(OP_PUSH, 8'h22, 1'b0);
    step(OP_PUSH, 8'h33, 1'b0);
    chk("push3", 8'h33, 8'h22, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_PUSH, 8'h44, 1'b0);
    chk("push4", 8'h44, 8'h33, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Overflow discards 0x11, then drain.
    step(OP_PUSH, 8'h55, 1'b0);
    chk("ovf_push", 8'h55, 8'h44, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("pop1", 8'h44, 8'h33, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("pop2", 8'h33, 8'h22, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("pop3", 8'h22, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("pop4", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(OP_HOLD, 8'hFF, 1'b1);
    chk("clr_ovf", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_HOLD, 8'hFF, 1'b0);
    chk("hold", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Underflow, clear, and set-wins-over-clear.
    step(OP_POP, 8'h00, 1'b0);
    chk("unf_pop", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(OP_HOLD, 8'h00, 1'b0);
    chk("unf_sticky", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(OP_HOLD, 8'h00, 1'b1);
    chk("clr_unf", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_POP, 8'h00, 1'b1);
    chk("unf_set_wins", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(OP_HOLD, 8'h00, 1'b1);

    // Replace top with two entries.
    step(OP_PUSH, 8'hB0, 1'b0);
    step(OP_PUSH, 8'hA0, 1'b0);
    chk("pre_repl", 8'hA0, 8'hB0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_REPL, 8'hC3, 1'b0);
    chk("repl", 8'hC3, 8'hB0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("repl_pop1", 8'hB0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_POP, 8'h00, 1'b0);
    chk("repl_pop2", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_REPL, 8'h7E, 1'b0);
    chk("repl_empty", 8'h7E, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with three entries.
    step(OP_PUSH, 8'h01, 1'b0);
    step(OP_PUSH, 8'h02, 1'b0);
    chk("pre_rst", 8'h02, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.s = OP_HOLD;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(OP_PUSH, 8'h09, 1'b0);
    chk("post_rst", 8'h09, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.s = OP_HOLD;

    // Random stream on the 16x2 stack against a queue model.
    rst2_n = 1'b1;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      sv = 2'($urandom_range(0, 3));
      iv = 16'($urandom);
      cv = ($urandom_range(0, 7) == 0);
      bus2.s       = sv;
      bus2.i       = iv;
      bus2.err_clr = cv;
      @(posedge ck);
      #1;
      case (sv)
        2'b10: begin
          if (q.size() == 2) begin
            void'(q.pop_back());
            ovf_m = 1'b1;
          end else begin
            ovf_m = ovf_m & ~cv;
          end
          q.push_front(iv);
          unf_m = unf_m & ~cv;
        end
        2'b01: begin
          if (q.size() == 0) begin
            unf_m = 1'b1;
          end else begin
            void'(q.pop_front());
            unf_m = unf_m & ~cv;
          end
          ovf_m = ovf_m & ~cv;
        end
        2'b11: begin
          if (q.size() == 0) q.push_front(iv);
          else q[0] = iv;
          ovf_m = ovf_m & ~cv;
          unf_m = unf_m & ~cv;
        end
        default: begin
          ovf_m = ovf_m & ~cv;
          unf_m = unf_m & ~cv;
        end
      endcase
      check("rnd.T",     32'(bus2.T),     (q.size() > 0) ? 32'(q[0]) : 32'd0);
      check("rnd.N",     32'(bus2.N),     (q.size() > 1) ? 32'(q[1]) : 32'd0);
      check("rnd.count", 32'(bus2.count), 32'(q.size()));
      check("rnd.empty", 32'(bus2.empty), 32'(q.size() == 0));
      check("rnd.full",  32'(bus2.full),  32'(q.size() == 2));
      check("rnd.ovf",   32'(bus2.ovf),   32'(ovf_m));
      check("rnd.unf",   32'(bus2.unf),   32'(unf_m));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised last-in-first-out register stack. It is the successor to the fixed 8-bit, 4-deep operand stack in the Mica2 datapath. It adds configurable width and depth, a replace-top operation, a second-of-stack output, an occupancy count, full/empty flags, and sticky overflow/underflow error flags. It sits between the instruction decoder (which drives the operation select) and the ALU (which consumes top and next-of-stack).

## Interface

Parameters:
- WIDTH, default 8: bits per stack entry.
- DEPTH, default 4: number of entries; legal range is 2 or more.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i  in  WIDTH  data to push or to write into the top entry.
- s  in  2  operation select: 00 hold, 01 pop, 10 push, 11 replace top.
- err_clr  in  1  synchronous clear of the sticky error flags.
- T  out  WIDTH  top-of-stack entry (entry 0).
- N  out  WIDTH  next-of-stack entry (entry 1).
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky: a push occurred while full.
- unf  out  1  sticky: a pop occurred while empty.

## Operation

- Storage: entries e[0..DEPTH-1]; e[0] is the top. The block is a pure shift structure: entries move, there is no pointer.
- Hold (00): no change to any state.
- Push (10): e[0] <= i; e[k] <= e[k-1] for k ≥ 1; the old e[DEPTH-1] is discarded.
  - Not full: count increments.
  - Full: count stays DEPTH, and ovf is set.
- Pop (01): e[k] <= e[k+1]; e[DEPTH-1] <= 0.
  - Not empty: count decrements.
  - Empty: count stays 0, unf is set, and the entries (already all zero) stay zero.
- Replace (11): e[0] <= i; the other entries are unchanged.
  - If empty: count becomes 1.
  - Otherwise: count is unchanged.
  - Replace never sets an error flag.
- Invalid entries always hold 0. Consequently, T = 0 when empty and N = 0 when count < 2.
- Error flags:
  - ovf and unf stay set until err_clr or reset.
  - If err_clr is asserted in the same cycle as a new error event, the set wins and the flag ends at 1.
- No arithmetic wrap: count saturates at 0 and at DEPTH.

## Timing

- Reset (asynchronous assert): all entries = 0, count = 0, empty = 1, full = 0, ovf = 0, unf = 0, so T = 0 and N = 0.
- Reset deassertion is synchronised externally. The first active edge after release may carry an operation.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: one cycle. An operation sampled at edge n is visible on T, N, count, flags and error outputs after edge n.
- All outputs are decoded from registers only. There is no combinational path from i, s or err_clr to any output.
- One operation per cycle; back-to-back operations are permitted with no bubbles.
- There is no handshake: the decoder is responsible for honouring full/empty. Violations are absorbed as described above and flagged.

## Structure

- Shared package stack_pkg:
  - Operation encodings: OP_HOLD=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11.
  - A count-width function, CNT_W(DEPTH) = $clog2(DEPTH+1).
- One sub-module, stack_occ: the occupancy counter plus empty/full/ovf/unf logic. It takes s, err_clr, ck and rst_n, and produces count and all four flags.
- The entry array and shift muxing stay in param_stack.

## Test plan

All scenarios use WIDTH=8, DEPTH=4.

- Reset, then push 0x11, 0x22, 0x33 -> T=0x33, N=0x22, count=3, empty=0, full=0.
- From 4 entries (0x44 top, 0x11 bottom), push 0x55 -> T=0x55, N=0x44, count=4, ovf=1; then four pops -> T sequence 0x44, 0x33, 0x22, 0x00, and empty is reached after the fourth pop. 0x11 is lost.
- Empty stack, pop -> count=0, T=0x00, unf=1. Then err_clr for one cycle -> unf=0. Pop together with err_clr asserted -> unf=1.
- count=2 (T=0xA0, N=0xB0), replace with 0xC3 -> T=0xC3, N=0xB0, count=2. On an empty stack, replace with 0x7E -> T=0x7E, count=1, no error flags.
- Reset asserted asynchronously between edges while count=3 -> T, N and count go to 0 and empty goes to 1 immediately. The first push after release yields count=1.
- Regression with DEPTH=2 and WIDTH=16: random s/i streams checked against a queue-based reference model on every cycle for T, N, count and flags.
